// File: rtl/exec_seq_pkg.sv
// Shared constants and types for the rysyCore execute-stage sequencer.
package exec_seq_pkg;

  // Datapath / PC width of the core.
  localparam int RYSY_REG_LEN = 32;

  // Default width of the redirect counter.
  localparam int FLUSH_CNT_W_DEF = 16;

  // ALU operand-1 select encodings.
  localparam logic ALU1_RS = 1'b0;
  localparam logic ALU1_PC = 1'b1;

  // Sequencer states: normal flow, or the one cycle after a PC load while
  // fetch still presents the stale instruction.
  typedef enum logic {
    SEQ_RUN   = 1'b0,
    SEQ_REDIR = 1'b1
  } seq_state_e;

endpackage : exec_seq_pkg

// File: rtl/seq_stage_reg.sv
// One pipeline stage register: PC, operand-1 select and valid tag.
// hold_i freezes the stage; kill_i clears only the valid bit of the
// captured entry, so killed entries keep their PC and select values.
module seq_stage_reg
  import exec_seq_pkg::*;
#(
  parameter int W = RYSY_REG_LEN
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         hold_i,
  input  logic         kill_i,
  input  logic [W-1:0] pc_i,
  input  logic         sel_i,
  input  logic         vld_i,
  output logic [W-1:0] pc_o,
  output logic         sel_o,
  output logic         vld_o
);

  logic [W-1:0] pc_q;
  logic         sel_q;
  logic         vld_q;

  // Capture the upstream entry unless frozen; a kill drops its valid bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q  <= '0;
      sel_q <= ALU1_RS;
      vld_q <= 1'b0;
    end else if (!hold_i) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values,
      // which is what lets D and E shift as a true pipeline.
      pc_q  <= pc_i;
      sel_q <= sel_i;
      vld_q <= vld_i & ~kill_i;
    end
  end

  assign pc_o  = pc_q;
  assign sel_o = sel_q;
  assign vld_o = vld_q;

endmodule : seq_stage_reg

// File: rtl/exec_seq.sv
// Execute-stage sequencer: carries fetch PC, operand-1 select and valid
// through decode into execute, honours stalls, and on a taken branch kills
// the two younger instructions, strobes the PC load and counts redirects.
module exec_seq
  import exec_seq_pkg::*;
#(
  parameter int REG_LEN     = RYSY_REG_LEN,
  parameter int FLUSH_CNT_W = FLUSH_CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [REG_LEN-1:0]     pc,
  input  logic                   fetch_vld,
  input  logic                   stall,
  input  logic                   dec_alu1_sel,
  input  logic                   br_taken,
  output logic [REG_LEN-1:0]     ex_pc,
  output logic                   alu1_sel,
  output logic                   ex_vld,
  output logic                   flush,
  output logic                   pc_load,
  output logic [FLUSH_CNT_W-1:0] flush_cnt
);

  seq_state_e             state_q, state_d;
  logic [FLUSH_CNT_W-1:0] cnt_q, cnt_d;
  logic [REG_LEN-1:0]     d_pc;
  logic                   d_sel;
  logic                   d_vld;
  logic                   fetch_take;
  logic                   redir;

  // A redirect is only accepted for a real instruction in a moving pipeline.
  assign redir      = ex_vld & br_taken & ~stall;
  assign flush      = redir;
  assign pc_load    = redir;
  // Right after a PC load the fetch output is stale, so it enters as a bubble.
  assign fetch_take = fetch_vld & (state_q == SEQ_RUN);

  seq_stage_reg #(.W(REG_LEN)) u_d_stage (
    .clk    (clk),
    .rst    (rst),
    .hold_i (stall),
    .kill_i (redir),
    .pc_i   (pc),
    .sel_i  (dec_alu1_sel),
    .vld_i  (fetch_take),
    .pc_o   (d_pc),
    .sel_o  (d_sel),
    .vld_o  (d_vld)
  );

  seq_stage_reg #(.W(REG_LEN)) u_e_stage (
    .clk    (clk),
    .rst    (rst),
    .hold_i (stall),
    .kill_i (redir),
    .pc_i   (d_pc),
    .sel_i  (d_sel),
    .vld_i  (d_vld),
    .pc_o   (ex_pc),
    .sel_o  (alu1_sel),
    .vld_o  (ex_vld)
  );

  // Next-state and saturating redirect count; both hold while stalled.
  always_comb begin
    // NOTE: defaults first so every path assigns every output (no latches).
    state_d = state_q;
    cnt_d   = cnt_q;
    if (redir && (cnt_q != '1)) begin
      cnt_d = cnt_q + FLUSH_CNT_W'(1);
    end
    unique case (state_q)
      SEQ_RUN:   if (redir)  state_d = SEQ_REDIR;
      SEQ_REDIR: if (!stall) state_d = SEQ_RUN;
      default:   state_d = SEQ_RUN;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SEQ_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign flush_cnt = cnt_q;

endmodule : exec_seq
